// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider: 2W-bit unsigned dividend / W-bit divisor -> W-bit quotient/remainder.
// One quotient bit per clock; divide-by-zero and quotient overflow are resolved on accept.
module seq_divider_32by16 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   quotient,
  output logic [W-1:0]   remainder,
  output logic           div_zero,
  output logic           ovf
);
  localparam int CW = $clog2(W+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic [W:0]    r, t, r_nxt;
  logic [W-1:0]  q, q_nxt, dvs;
  logic [CW-1:0] cnt;
  logic          accept, err_zero, err_ovf, ge;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign err_zero  = (divisor == '0);
  // High half >= divisor means the quotient needs more than W bits.
  assign err_ovf   = (dividend[2*W-1:W] >= divisor);

  // One restoring step: shift the next dividend bit into the partial remainder.
  assign t     = {r[W-1:0], q[W-1]};
  assign ge    = (t >= {1'b0, dvs});
  assign r_nxt = ge ? (t - {1'b0, dvs}) : t;
  assign q_nxt = {q[W-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = (err_zero || err_ovf) ? DONE : CALC;
      CALC: if (cnt == CW'(1)) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          dvs <= divisor;
          if (err_zero) begin
            div_zero  <= 1'b1;
            ovf       <= 1'b0;
            quotient  <= '1;
            remainder <= dividend[W-1:0];
          end else if (err_ovf) begin
            div_zero  <= 1'b0;
            ovf       <= 1'b1;
            quotient  <= '1;
            remainder <= '0;
          end else begin
            div_zero <= 1'b0;
            ovf      <= 1'b0;
            r        <= {1'b0, dividend[2*W-1:W]};
            q        <= dividend[W-1:0];
            cnt      <= CW'(W);
          end
        end
        CALC: begin
          r   <= r_nxt;
          q   <= q_nxt;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            quotient  <= q_nxt;
            remainder <= r_nxt[W-1:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider_32by16.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, and
// random operands checked against plain / and % arithmetic.
module tb_seq_divider_32by16;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, div_zero, ovf;
  logic [31:0] dividend;
  logic [15:0] divisor, quotient, remainder;

  int nvec = 0;
  int nerr = 0;

  seq_divider_32by16 #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] dd;
    logic [15:0] ds;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Drive one operation at a negedge; returns once the accept edge has passed.
  task automatic start_op(input logic [31:0] dd, input logic [15:0] ds);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin nvec++; nerr++; $display("FAIL in_ready_timeout: got 0 expected 1"); end
    dividend = dd;
    divisor  = ds;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // lat = clock edges after the accept edge before out_valid is seen (0 = next cycle).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
    if (lat >= 100) begin nvec++; nerr++; $display("FAIL out_valid_timeout: got 0 expected 1"); end
  endtask

  task automatic drain(input int stall);
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t        tbl[8];
  int          lat;
  logic [15:0] hold_q, hold_r, ds;
  logic [31:0] dd;
  logic        saw_valid;

  initial begin
    tbl[0] = '{32'h00000006, 16'h0003, 16'h0002, 16'h0000, 1'b0, 1'b0, 16};
    tbl[1] = '{32'h06260160, 16'h5678, 16'h1234, 16'h0100, 1'b0, 1'b0, 16};
    tbl[2] = '{32'hFFFE0001, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16};
    tbl[3] = '{32'hABCD1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0};
    tbl[4] = '{32'h00010000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0};
    tbl[5] = '{32'h0000FFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16};
    tbl[6] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 0};
    tbl[7] = '{32'h0000ABCD, 16'h0100, 16'h00AB, 16'h00CD, 1'b0, 1'b0, 16};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_quotient",  {16'b0, quotient},  32'd0);
    chk("rst_remainder", {16'b0, remainder}, 32'd0);
    chk("rst_flags",     {30'b0, div_zero, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      start_op(tbl[i].dd, tbl[i].ds);
      wait_done(lat);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d_q", i), {16'b0, quotient}, {16'b0, tbl[i].q});
      chk($sformatf("tbl%0d_r", i), {16'b0, remainder}, {16'b0, tbl[i].r});
      chk($sformatf("tbl%0d_flags", i), {30'b0, div_zero, ovf}, {30'b0, tbl[i].dz, tbl[i].ov});
      drain(0);
      chk($sformatf("tbl%0d_idle", i), {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Stall in DONE while hammering in_valid: result must hold, no second accept.
    start_op(32'h06260160, 16'h5678);
    wait_done(lat);
    hold_q = quotient; hold_r = remainder;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0] ? 1'b0 : 1'b1;
      dividend = 32'h00000064; divisor = 16'h0007;
      @(negedge clk);
      chk("stall_q", {16'b0, quotient}, 32'h1234);
      chk("stall_r", {16'b0, remainder}, 32'h0100);
      chk("stall_hs", {30'b0, in_ready, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    drain(0);
    chk("stall_release", {30'b0, in_ready, out_valid}, 32'd2);
    chk("idle_hold_q", {16'b0, quotient}, {16'b0, hold_q});
    chk("idle_hold_r", {16'b0, remainder}, {16'b0, hold_r});

    // Reset mid-CALC discards the operation.
    start_op(32'h06260160, 16'h5678);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_q", {16'b0, quotient}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    chk("midrst_no_valid", {31'b0, saw_valid}, 32'd0);
    start_op(32'h00000064, 16'h0007);
    wait_done(lat);
    chk("post_rst_q", {16'b0, quotient}, 32'h000E);
    chk("post_rst_r", {16'b0, remainder}, 32'h0002);
    drain(0);

    // Random non-error operands with random consumer stalls.
    for (int i = 0; i < 1000; i++) begin
      ds = 16'($urandom_range(1, 65535));
      dd = {16'($urandom % ds), 16'($urandom)};
      start_op(dd, ds);
      wait_done(lat);
      chk("rnd_lat", lat, 16);
      chk($sformatf("rnd_q %h/%h", dd, ds), {16'b0, quotient}, dd / {16'b0, ds});
      chk($sformatf("rnd_r %h/%h", dd, ds), {16'b0, remainder}, dd % {16'b0, ds});
      chk("rnd_flags", {30'b0, div_zero, ovf}, 32'd0);
      drain(int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
